pe_array_sequencer: RTL and testbench

//  Sequencer for the 3x3 PE array: generates the per-group read/start wavefront, filter-row loads,

---
 rtl/pe_array_sequencer.sv | 159 +++++++++++++++
 tb/tb_pe_array_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_sequencer.sv
// Sequences filter loads, the skewed 5-group read/start wavefront, OS end/drain and done for one job per start.
// Outputs decode registered state only; start is ignored while busy and abort returns to IDLE on the next edge.
`timescale 1ns/1ps
module pe_array_sequencer #(
   parameter int LEN_W    = 8,
   parameter int RS_FLUSH = 4
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             start,
   input  logic             abort,
   input  logic             cfg_mode,
   input  logic [LEN_W-1:0] cfg_len,
   output logic [4:0]       PERead,
   output logic [4:0]       PEStart,
   output logic [2:0]       filtRead,
   output logic             mode,
   output logic             end_OS,
   output logic [3:0]       OSOutSel,
   output logic             busy,
   output logic             done
);

   // One extra bit so the STREAM count can reach L+3 at the maximum length without wrapping.
   localparam int CW = LEN_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_F,
      S_STREAM,
      S_END_OS,
      S_DRAIN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [LEN_W-1:0] len_q, len_nxt;
   logic             mode_nxt;
   logic [CW-1:0]    stream_last;
   logic [CW:0]      sx, lo, hi;
   logic [4:0]       wave;

   assign stream_last = CW'(len_q) + CW'(3);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state <= S_IDLE;
         cnt   <= '0;
         len_q <= '0;
         mode  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         len_q <= len_nxt;
         mode  <= mode_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len_q;
      mode_nxt  = mode;
      PERead    = '0;
      PEStart   = '0;
      filtRead  = '0;
      end_OS    = 1'b0;
      OSOutSel  = '0;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      sx        = {1'b0, cnt};
      lo        = '0;
      hi        = '0;
      wave      = '0;

      // Group g covers stream slots g .. g+L-1.
      for (int g = 0; g < 5; g++) begin
         lo      = (CW+1)'(g);
         hi      = lo + (CW+1)'(len_q);
         wave[g] = (sx >= lo) && (sx < hi);
      end

      case (state)
         S_LOAD_F: filtRead = 3'b001 << cnt[1:0];
         S_STREAM: begin
            PERead  = wave;
            PEStart = wave;
            if (mode && (wave != 5'd0)) filtRead = 3'b111;
         end
         S_END_OS: end_OS = 1'b1;
         S_DRAIN:  OSOutSel = 4'(cnt) + 4'd1;
         default: ;
      endcase

      if (abort) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         mode_nxt  = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_nxt  = cfg_mode;
                  len_nxt   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                  cnt_nxt   = '0;
                  state_nxt = cfg_mode ? S_STREAM : S_LOAD_F;
               end
            end
            S_LOAD_F: begin
               if (cnt == CW'(2)) begin
                  cnt_nxt   = '0;
                  state_nxt = S_STREAM;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_STREAM: begin
               if (cnt == stream_last) begin
                  cnt_nxt   = '0;
                  state_nxt = mode ? S_END_OS : S_FLUSH;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_END_OS: begin
               cnt_nxt   = '0;
               state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
               if (cnt == CW'(8)) begin
                  cnt_nxt   = '0;
                  state_nxt = S_DONE;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_FLUSH: begin
               if (cnt == CW'(RS_FLUSH - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = S_DONE;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            S_DONE: begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Randomized scoreboard bench: stimulus pushes the per-cycle expected outputs of each accepted job,
// a negedge monitor pops and compares every cycle and also checks per-job busy length and strobe counts.
`timescale 1ns/1ps
module tb_pe_array_sequencer;
   localparam int LEN_W    = 8;
   localparam int RS_FLUSH = 4;

   logic             clk = 1'b0;
   logic             nRST = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             cfg_mode = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic [4:0]       PERead, PEStart;
   logic [2:0]       filtRead;
   logic             mode, end_OS, busy, done;
   logic [3:0]       OSOutSel;

   pe_array_sequencer #(.LEN_W(LEN_W), .RS_FLUSH(RS_FLUSH)) dut (
      .clk(clk), .nRST(nRST), .start(start), .abort(abort),
      .cfg_mode(cfg_mode), .cfg_len(cfg_len),
      .PERead(PERead), .PEStart(PEStart), .filtRead(filtRead), .mode(mode),
      .end_OS(end_OS), .OSOutSel(OSOutSel), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] st;
      logic [2:0] fr;
      logic       md;
      logic       eo;
      logic [3:0] sel;
      logic       bz;
      logic       dn;
   } out_t;

   typedef struct packed {
      logic        md;
      logic [31:0] len;
   } job_t;

   out_t exp_q[$];
   job_t job_q[$];
   logic exp_mode = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   done_exp = 0;
   int   done_seen = 0;
   int   busy_run = 0;
   int   pe_cnt[5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, req);
      end
   endtask

   function automatic out_t idle_vec(input logic m);
      out_t v;
      v    = '0;
      v.md = m;
      return v;
   endfunction

   // Expected cycle-by-cycle outputs of a job, straight from the job description.
   task automatic push_job(input logic m, input logic [LEN_W-1:0] cl);
      int   L;
      out_t v;
      job_t j;
      L = (cl == 0) ? 1 : int'(cl);
      if (!m) begin
         for (int i = 0; i < 3; i++) begin
            v = idle_vec(m); v.bz = 1'b1; v.fr = 3'(1 << i);
            exp_q.push_back(v);
         end
      end
      for (int s = 0; s < L + 4; s++) begin
         v = idle_vec(m); v.bz = 1'b1;
         for (int g = 0; g < 5; g++) if (s >= g && s < g + L) v.st[g] = 1'b1;
         v.rd = v.st;
         if (m && v.st != 0) v.fr = 3'b111;
         exp_q.push_back(v);
      end
      if (m) begin
         v = idle_vec(m); v.bz = 1'b1; v.eo = 1'b1;
         exp_q.push_back(v);
         for (int k = 1; k <= 9; k++) begin
            v = idle_vec(m); v.bz = 1'b1; v.sel = 4'(k);
            exp_q.push_back(v);
         end
      end else begin
         for (int k = 0; k < RS_FLUSH; k++) begin
            v = idle_vec(m); v.bz = 1'b1;
            exp_q.push_back(v);
         end
      end
      v = idle_vec(m); v.bz = 1'b1; v.dn = 1'b1;
      exp_q.push_back(v);
      j.md = m; j.len = 32'(L);
      job_q.push_back(j);
      exp_mode = m;
      done_exp++;
   endtask

   task automatic cancel_jobs();
      exp_q.delete();
      done_exp = done_exp - job_q.size();
      job_q.delete();
      exp_mode = 1'b0;
   endtask

   always @(negedge clk) begin
      out_t got, req;
      job_t j;
      int   blen;
      got = {PERead, PEStart, filtRead, mode, end_OS, OSOutSel, busy, done};
      if (exp_q.size() > 0) req = exp_q.pop_front();
      else req = idle_vec(exp_mode);
      chk("cycle_outputs", 32'(got), 32'(req));
      if (busy) begin
         busy_run++;
         for (int g = 0; g < 5; g++) if (PEStart[g]) pe_cnt[g]++;
      end
      if (done) begin
         done_seen++;
         if (job_q.size() > 0) begin
            j = job_q.pop_front();
            blen = j.md ? (int'(j.len) + 4 + 1 + 9 + 1) : (3 + int'(j.len) + 4 + RS_FLUSH + 1);
            chk("job_busy_cycles", 32'(busy_run), 32'(blen));
            for (int g = 0; g < 5; g++) chk("group_active_cycles", 32'(pe_cnt[g]), j.len);
         end else begin
            chk("unexpected_done", 32'(1), 32'(0));
         end
      end
      if (!busy || done) begin
         busy_run = 0;
         for (int g = 0; g < 5; g++) pe_cnt[g] = 0;
      end
   end

   task automatic rand_cfg();
      cfg_mode = 1'($urandom);
      cfg_len  = LEN_W'($urandom);
   endtask

   task automatic issue(input logic m, input logic [LEN_W-1:0] cl);
      cfg_mode = m;
      cfg_len  = cl;
      start    = 1'b1;
      @(posedge clk);
      push_job(m, cl);
      #1;
      start = 1'b0;
      rand_cfg();
   endtask

   // Runs until every queued expectation is consumed; stray starts and cfg noise must be ignored.
   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(posedge clk);
         #1;
         rand_cfg();
         start = (exp_q.size() >= 2) && ($urandom_range(0, 7) == 0);
         n++;
      end
      start = 1'b0;
      chk("job_completes_in_budget", 32'(exp_q.size()), 32'(0));
      if (exp_q.size() > 0) cancel_jobs();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int m;
      int cl;
      #2;
      chk("reset_outputs", 32'({PERead, PEStart, filtRead, mode, end_OS, OSOutSel, busy, done}), 32'(0));
      repeat (2) @(posedge clk);
      #1 nRST = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b0, 8'd2);
      wait_idle();
      issue(1'b1, 8'd3);
      wait_idle();
      issue(1'b0, 8'd0);
      wait_idle();
      issue(1'b1, 8'd0);
      wait_idle();

      // Start pulsed during the fourth DRAIN cycle must not queue a second job.
      issue(1'b1, 8'd5);
      repeat (5 + 8) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();
      repeat (4) @(posedge clk);
      #1;

      // abort together with start in IDLE: stays IDLE and mode clears.
      cfg_mode = 1'b1; cfg_len = 8'd3; start = 1'b1; abort = 1'b1;
      @(posedge clk);
      exp_mode = 1'b0;
      #1 start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // abort while STREAM is at s=2, for both modes.
      for (int k = 0; k < 2; k++) begin
         issue(1'(k), 8'd4);
         repeat ((k == 1 ? 0 : 3) + 2) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk);
         cancel_jobs();
         #1 abort = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end

      // Asynchronous reset in the middle of LOAD_F, then a normal job.
      issue(1'b0, 8'd4);
      @(posedge clk);
      #1 nRST = 1'b0;
      cancel_jobs();
      #1;
      chk("async_reset_outputs", 32'({PERead, PEStart, filtRead, mode, end_OS, OSOutSel, busy, done}), 32'(0));
      @(posedge clk);
      #1 nRST = 1'b1;
      @(posedge clk);
      #1;
      issue(1'b0, 8'd3);
      wait_idle();

      for (int t = 0; t < 30; t++) begin
         m = $urandom_range(0, 1);
         case ($urandom_range(0, 9))
            0:       cl = 0;
            1:       cl = 255;
            default: cl = $urandom_range(1, 12);
         endcase
         issue(1'(m), LEN_W'(cl));
         wait_idle();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("done_pulse_count", 32'(done_seen), 32'(done_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
